// File: rtl/tlb_lookup_fill.sv
// Fully associative TLB array with lookup/refill controller.
// Hits respond one cycle after accept. A miss issues one page-table walk,
// fills a victim entry (lowest invalid, else the PLRU choice) and responds.
module tlb_lookup_fill #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned VPN_W   = 27,
  parameter int unsigned PPN_W   = 44,
  parameter int unsigned ASID_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [VPN_W-1:0]           req_vpn_i,
  input  logic [ASID_W-1:0]          req_asid_i,
  output logic                       resp_valid_o,
  output logic                       resp_hit_o,
  output logic                       resp_fault_o,
  output logic [PPN_W-1:0]           resp_ppn_o,
  input  logic                       flush_i,
  output logic                       ptw_req_valid_o,
  input  logic                       ptw_req_ready_i,
  output logic [VPN_W-1:0]           ptw_req_vpn_o,
  output logic [ASID_W-1:0]          ptw_req_asid_o,
  input  logic                       ptw_resp_valid_i,
  input  logic                       ptw_resp_error_i,
  input  logic [PPN_W-1:0]           ptw_resp_ppn_i,
  output logic                       plru_access_hit_o,
  output logic [$clog2(ENTRIES)-1:0] plru_access_idx_o,
  input  logic [$clog2(ENTRIES)-1:0] plru_repl_idx_i
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, PTW_REQ, PTW_WAIT, RESP} state_t;

  state_t state, state_nxt;

  // Entry storage
  logic [ENTRIES-1:0] valid;
  logic [VPN_W-1:0]   ent_vpn  [ENTRIES];
  logic [ASID_W-1:0]  ent_asid [ENTRIES];
  logic [PPN_W-1:0]   ent_ppn  [ENTRIES];

  // Request context. idx_q/ppn_q hold the hit index/ppn while a hit response
  // is pending in IDLE, and the victim/walk ppn during RESP.
  logic [VPN_W-1:0]   req_vpn_q;
  logic [ASID_W-1:0]  req_asid_q;
  logic               hit_q;
  logic [IDX_W-1:0]   idx_q;
  logic [PPN_W-1:0]   ppn_q;
  logic               fault_q;
  logic               drop_q;
  logic               fill_ok_q;

  logic               lk_hit;
  logic [IDX_W-1:0]   lk_idx;
  logic [PPN_W-1:0]   lk_ppn;
  logic               has_free;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   victim;
  logic               accept;
  logic               walk_done;
  logic               fill_en;

  // Associative match; the first (lowest-index) match wins.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    lk_ppn = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!lk_hit && valid[i] && ent_vpn[i] == req_vpn_i && ent_asid[i] == req_asid_i) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
        lk_ppn = ent_ppn[i];
      end
    end
  end

  // Victim choice: lowest invalid entry, otherwise the PLRU replacement index.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!has_free && !valid[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    victim = has_free ? free_idx : plru_repl_idx_i;
  end

  assign accept    = (state == IDLE) && req_valid_i && !flush_i;
  assign walk_done = (state == PTW_WAIT) && ptw_resp_valid_i;
  assign fill_en   = walk_done && !ptw_resp_error_i && !drop_q && !flush_i;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and output decode
  always_comb begin
    state_nxt         = state;
    req_ready_o       = 1'b0;
    resp_valid_o      = 1'b0;
    resp_hit_o        = 1'b0;
    resp_fault_o      = 1'b0;
    resp_ppn_o        = '0;
    ptw_req_valid_o   = 1'b0;
    ptw_req_vpn_o     = '0;
    ptw_req_asid_o    = '0;
    plru_access_hit_o = 1'b0;
    plru_access_idx_o = '0;
    unique case (state)
      IDLE: begin
        req_ready_o = !flush_i;
        if (hit_q) begin
          resp_valid_o      = 1'b1;
          resp_hit_o        = 1'b1;
          resp_ppn_o        = ppn_q;
          plru_access_hit_o = 1'b1;
          plru_access_idx_o = idx_q;
        end
        if (accept && !lk_hit) state_nxt = PTW_REQ;
      end
      PTW_REQ: begin
        ptw_req_valid_o = 1'b1;
        ptw_req_vpn_o   = req_vpn_q;
        ptw_req_asid_o  = req_asid_q;
        if (ptw_req_ready_i) state_nxt = PTW_WAIT;
      end
      PTW_WAIT: begin
        if (ptw_resp_valid_i) state_nxt = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_hit_o   = !fault_q;
        resp_fault_o = fault_q;
        resp_ppn_o   = fault_q ? '0 : ppn_q;
        if (fill_ok_q) begin
          plru_access_hit_o = 1'b1;
          plru_access_idx_o = idx_q;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request context, walk result capture and the flush drop flag
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      req_vpn_q  <= '0;
      req_asid_q <= '0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
      ppn_q      <= '0;
      fault_q    <= 1'b0;
      drop_q     <= 1'b0;
      fill_ok_q  <= 1'b0;
    end else begin
      hit_q <= accept && lk_hit;
      if (accept) begin
        req_vpn_q  <= req_vpn_i;
        req_asid_q <= req_asid_i;
        idx_q      <= lk_idx;
        ppn_q      <= lk_ppn;
      end
      if (state == IDLE)
        drop_q <= 1'b0;
      else if (flush_i && (state == PTW_REQ || state == PTW_WAIT))
        drop_q <= 1'b1;
      if (walk_done) begin
        fault_q   <= ptw_resp_error_i;
        fill_ok_q <= fill_en;
        ppn_q     <= ptw_resp_error_i ? '0 : ptw_resp_ppn_i;
        idx_q     <= victim;
      end
    end
  end

  // Entry array update; flush takes priority over a same-cycle fill
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ent_vpn[i]  <= '0;
        ent_asid[i] <= '0;
        ent_ppn[i]  <= '0;
      end
    end else begin
      if (flush_i)
        valid <= '0;
      else if (fill_en)
        valid[victim] <= 1'b1;
      if (fill_en) begin
        ent_vpn[victim]  <= req_vpn_q;
        ent_asid[victim] <= req_asid_q;
        ent_ppn[victim]  <= ptw_resp_ppn_i;
      end
    end
  end

endmodule
